pulse_stretch_driver: RTL and testbench

Output-side counterpart of the input debouncer. It accepts single-cycle command pulses (e.g. "open gate", "beep") from control logic and drives a physical output line high for a fixed hold time. It enforces a minimum off-gap between activations and queues a bounded number of requests that arrive while the output is busy. It sits between the parking controller FSM and actuator/LED/buzzer pins.

---
 rtl/pulse_stretch_driver_pkg.sv | 33 +++
 rtl/pulse_stretch_driver.sv | 134 +++++++++++++
 tb/tb_pulse_stretch_driver.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/pulse_stretch_driver_pkg.sv
// Shared definitions for the pulse stretch driver.
//   - pstate_t      : FSM state encoding (IDLE, ACTIVE, GAP)
//   - cycles_from_hz: converts a clock frequency and a rate in Hz into a cycle count
//   - cnt_width     : width of the hold/gap cycle counter
//   - pend_width    : width of the pending-request counter
package pulse_stretch_driver_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    GAP    = 2'd2
  } pstate_t;

  function automatic int cycles_from_hz(input int clk_frequency, input int hz);
    return clk_frequency / hz;
  endfunction

  // Counter must hold max(hold, gap) - 1. The result is clamped to at least
  // one bit so that 1-cycle hold/gap settings still elaborate.
  function automatic int cnt_width(input int hold_cycles, input int gap_cycles);
    int m;
    m = (hold_cycles > gap_cycles) ? hold_cycles : gap_cycles;
    return ($clog2(m) < 1) ? 1 : $clog2(m);
  endfunction

  // Pending counter has to represent 0..max_pending inclusive.
  function automatic int pend_width(input int max_pending);
    return $clog2(max_pending + 1);
  endfunction

endpackage

// File: rtl/pulse_stretch_driver.sv
// Pulse stretch driver: turns single-cycle command pulses into a fixed-length
// high level on an actuator/LED/buzzer line, enforces a minimum low gap
// between activations and queues a bounded number of requests.
// Ports:
//   clk      - system clock, rising edge
//   reset    - asynchronous, active-high reset
//   inPulse  - request; every cycle sampled high counts as one request
//   outLevel - stretched output drive (registered)
//   busy     - high while ACTIVE or GAP (registered)
//   pending  - number of queued requests (registered)
//   overflow - one-cycle pulse when a request is dropped on a full queue
module pulse_stretch_driver
  import pulse_stretch_driver_pkg::*;
#(
  parameter int CLK_FREQUENCY = 40_000_000,
  parameter int HOLD_HZ       = 2,
  parameter int GAP_HZ        = 10,
  parameter int MAX_PENDING   = 3
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               inPulse,
  output logic                               outLevel,
  output logic                               busy,
  output logic [pend_width(MAX_PENDING)-1:0] pending,
  output logic                               overflow
);

  localparam int HOLD_CYCLES = cycles_from_hz(CLK_FREQUENCY, HOLD_HZ);
  localparam int GAP_CYCLES  = cycles_from_hz(CLK_FREQUENCY, GAP_HZ);
  localparam int CNT_W       = cnt_width(HOLD_CYCLES, GAP_CYCLES);
  localparam int PEND_W      = pend_width(MAX_PENDING);

  localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]  GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [PEND_W-1:0] PEND_MAX  = PEND_W'(MAX_PENDING);

  pstate_t           state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PEND_W-1:0] pending_q, pending_d;
  logic              out_q, out_d;
  logic              busy_q, busy_d;
  logic              overflow_q, overflow_d;

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    pending_d  = pending_q;
    out_d      = out_q;
    overflow_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        // A request in IDLE starts immediately and never touches the queue.
        if (inPulse) begin
          state_d = ACTIVE;
          count_d = '0;
          out_d   = 1'b1;
        end
      end

      ACTIVE: begin
        if (count_q == HOLD_LAST) begin
          state_d = GAP;
          count_d = '0;
          out_d   = 1'b0;
        end else begin
          count_d = count_q + 1'b1;
        end
        if (inPulse) begin
          if (pending_q < PEND_MAX) pending_d = pending_q + 1'b1;
          else                      overflow_d = 1'b1;
        end
      end

      GAP: begin
        if (count_q == GAP_LAST) begin
          count_d = '0;
          if (pending_q != '0) begin
            // Dequeue one; a simultaneous new request re-fills that slot,
            // so it is accepted even on a full queue.
            state_d   = ACTIVE;
            out_d     = 1'b1;
            pending_d = inPulse ? pending_q : pending_q - 1'b1;
          end else if (inPulse) begin
            // Empty queue: the new request is consumed directly.
            state_d = ACTIVE;
            out_d   = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          count_d = count_q + 1'b1;
          if (inPulse) begin
            if (pending_q < PEND_MAX) pending_d = pending_q + 1'b1;
            else                      overflow_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
        count_d = '0;
        out_d   = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      count_q    <= '0;
      pending_q  <= '0;
      out_q      <= 1'b0;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      pending_q  <= pending_d;
      out_q      <= out_d;
      busy_q     <= busy_d;
      overflow_q <= overflow_d;
    end
  end

  assign outLevel = out_q;
  assign busy     = busy_q;
  assign pending  = pending_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_pulse_stretch_driver.sv
// Directed testbench for pulse_stretch_driver with HOLD_CYCLES=10,
// GAP_CYCLES=4, MAX_PENDING=2. Pulse pattern c drives inPulse during cycle c
// (relative to the start of a scenario); outputs are observed for cycle k=c+1.
module tb_pulse_stretch_driver;

  logic       clk = 1'b0;
  logic       reset;
  logic       inPulse;
  logic       outLevel;
  logic       busy;
  logic [1:0] pending;
  logic       overflow;

  int n_checks = 0;
  int n_errors = 0;

  pulse_stretch_driver #(
    .CLK_FREQUENCY(100),
    .HOLD_HZ      (10),
    .GAP_HZ       (25),
    .MAX_PENDING  (2)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .inPulse (inPulse),
    .outLevel(outLevel),
    .busy    (busy),
    .pending (pending),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic bit in_rng(input int k, input int lo, input int hi);
    return (k >= lo) && (k <= hi);
  endfunction

  // Stimulus: which relative cycles carry a request, per scenario.
  function automatic bit pulse_at(input int t, input int c);
    case (t)
      1: return c == 0;
      2: return (c == 0) || (c == 3);
      3: return (c == 0) || (c == 2) || (c == 3) || (c == 4);
      4: return (c == 0) || (c == 14);
      6: return in_rng(c, 0, 3);
      default: return 1'b0;
    endcase
  endfunction

  // Hand-derived expected outputs for observed cycle k.
  function automatic int exp_out(input int t, input int k);
    case (t)
      1: return int'(in_rng(k, 1, 10));
      2, 4: return int'(in_rng(k, 1, 10) || in_rng(k, 15, 24));
      3, 6: return int'(in_rng(k, 1, 10) || in_rng(k, 15, 24) || in_rng(k, 29, 38));
      default: return 0;
    endcase
  endfunction

  function automatic int exp_busy(input int t, input int k);
    case (t)
      1: return int'(in_rng(k, 1, 14));
      2, 4: return int'(in_rng(k, 1, 28));
      3, 6: return int'(in_rng(k, 1, 42));
      default: return 0;
    endcase
  endfunction

  function automatic int exp_pend(input int t, input int k);
    case (t)
      2: return int'(in_rng(k, 4, 14));
      3: return (k == 3) ? 1 : in_rng(k, 4, 14) ? 2 : in_rng(k, 15, 28) ? 1 : 0;
      6: return (k == 2) ? 1 : in_rng(k, 3, 14) ? 2 : in_rng(k, 15, 28) ? 1 : 0;
      default: return 0;
    endcase
  endfunction

  function automatic int exp_ovf(input int t, input int k);
    case (t)
      3: return int'(k == 5);
      6: return int'(k == 4);
      default: return 0;
    endcase
  endfunction

  task automatic run_scenario(input int t, input int ncyc);
    int errs_before;
    errs_before = n_errors;
    for (int c = 0; c < ncyc; c++) begin
      inPulse = pulse_at(t, c);
      @(posedge clk);
      #1;
      check_val($sformatf("t%0d k%0d outLevel", t, c + 1), int'(outLevel), exp_out(t, c + 1));
      check_val($sformatf("t%0d k%0d busy", t, c + 1), int'(busy), exp_busy(t, c + 1));
      check_val($sformatf("t%0d k%0d pending", t, c + 1), int'(pending), exp_pend(t, c + 1));
      check_val($sformatf("t%0d k%0d overflow", t, c + 1), int'(overflow), exp_ovf(t, c + 1));
    end
    inPulse = 1'b0;
    $display("scenario %0d: %0d cycles, %0d new errors", t, ncyc, n_errors - errs_before);
  endtask

  initial begin
    reset   = 1'b1;
    inPulse = 1'b0;
    #1;
    check_val("reset outLevel", int'(outLevel), 0);
    check_val("reset busy", int'(busy), 0);
    check_val("reset pending", int'(pending), 0);
    check_val("reset overflow", int'(overflow), 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;

    run_scenario(1, 18);
    run_scenario(2, 32);
    run_scenario(3, 46);
    run_scenario(4, 32);
    run_scenario(6, 46);

    // Scenario 5: asynchronous reset in the middle of ACTIVE with one queued.
    for (int c = 0; c < 5; c++) begin
      inPulse = (c == 0) || (c == 3);
      @(posedge clk);
      #1;
    end
    inPulse = 1'b0;
    check_val("t5 pre-reset outLevel", int'(outLevel), 1);
    check_val("t5 pre-reset pending", int'(pending), 1);
    reset = 1'b1;
    #1;
    check_val("t5 async outLevel", int'(outLevel), 0);
    check_val("t5 async busy", int'(busy), 0);
    check_val("t5 async pending", int'(pending), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_val("t5 held pending", int'(pending), 0);
    $display("scenario 5: reset mid-ACTIVE applied, rerunning single pulse");
    run_scenario(1, 18);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Safety net so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
